// File: rtl/qlf_k6n10_seq_div.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per operation.
// A zero divisor short-circuits straight to DONE with saturated quotient and pass-through remainder.
module qlf_k6n10_seq_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  // Partial remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the subtract's MSB is a clean borrow flag.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};
  assign borrow  = trial[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dsr_d = divisor;
          cnt_d = CW'(WIDTH);
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        quot_d = {quot_q[WIDTH-2:0], ~borrow};
        rem_d  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign valid       = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_qlf_k6n10_seq_div.sv
// Randomized self-checking bench for qlf_k6n10_seq_div against a plain-arithmetic division model.
module tb_qlf_k6n10_seq_div;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t exp_q[$];

  qlf_k6n10_seq_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return a;
    return a % b;
  endfunction

  // Called at a negedge; returns at a negedge after checking the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int k;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", 32'(ready), 32'd1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    k = 0;
    @(negedge clk);
    while (!valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), (b == 0) ? 32'd0 : 32'(W));
    chk("quotient", 32'(quotient), 32'(model_q(a, b)));
    chk("remainder", 32'(remainder), 32'(model_r(a, b)));
    chk("div_by_zero", 32'(div_by_zero), 32'(b == 0));
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, k);
    @(negedge clk);
    chk("valid_width", 32'(valid), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
    chk("hold_q", 32'(quotient), 32'(model_q(a, b)));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int last;
    int c;
    op_t e;
    op_t o;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd100, 16'd7);
    do_op(16'hFFFF, 16'd1);
    do_op(16'd5, 16'd9);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'd1234, 16'd0);
    do_op(16'd0, 16'd5);
    do_op(16'd0, 16'd0);

    // Abort mid-operation with an asynchronous reset.
    start    = 1'b1;
    dividend = 16'd200;
    divisor  = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd200, 16'd3);

    // start held high with fresh operands every cycle.
    last = -1;
    for (c = 0; c < 160; c++) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("b2b_q", 32'(quotient), 32'(model_q(e.a, e.b)));
          chk("b2b_r", 32'(remainder), 32'(model_r(e.a, e.b)));
          if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd18);
          $display("b2b %0d / %0d -> q=%0d r=%0d cyc=%0d", e.a, e.b, quotient, remainder, c);
          last = c;
        end
      end
      if (c < 120) begin
        o.a      = W'($urandom);
        o.b      = W'($urandom_range(1, 65535));
        start    = 1'b1;
        dividend = o.a;
        divisor  = o.b;
        if (ready) exp_q.push_back(o);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      do_op(pick_operand(), pick_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
